// File: rtl/dsi_lanes_distributor.sv
`default_nettype none
// ============================================================================
//  Module   : dsi_lanes_distributor
//  Purpose  : Splits the 32-bit DSI packet word stream byte-wise over 1-4
//             D-PHY lanes through an 8-byte buffer; drives the HS handshake.
//  Revision : 1.0
// ============================================================================
module dsi_lanes_distributor (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic [31:0] iface_write_data,
    input  logic [4:0]  iface_write_strb,
    input  logic        iface_write_rqst,
    input  logic        iface_last_word,
    output logic        iface_data_rqst,
    input  logic [1:0]  lanes_number,
    input  logic        phy_hs_active,
    output logic        hs_request,
    output logic [31:0] lane_data,
    output logic [3:0]  lane_valid,
    output logic        underflow_err,
    input  logic        err_clear,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQUEST = 2'd1,
        S_STREAM  = 2'd2,
        S_EXIT    = 2'd3
    } state_t;

    state_t      r_state_q,      w_state_d;
    logic [3:0]  r_count_q,      w_count_d;
    logic [63:0] r_buf_q,        w_buf_d;
    logic        r_last_seen_q,  w_last_seen_d;
    logic [1:0]  r_lanes_q,      w_lanes_d;
    logic [31:0] r_lane_data_q,  w_lane_data_d;
    logic [3:0]  r_lane_valid_q, w_lane_valid_d;
    logic        r_err_q,        w_err_d;

    logic        w_hs_phase;
    logic        w_push;
    logic [2:0]  w_push_cnt;
    logic [3:0]  w_n;
    logic [3:0]  w_pop_cnt;
    logic [3:0]  w_remain;
    logic [63:0] w_push_bytes;
    logic        w_unused_sop;

    assign w_unused_sop    = iface_write_strb[4];
    assign w_hs_phase      = (r_state_q == S_REQUEST) || (r_state_q == S_STREAM);
    assign iface_data_rqst = w_hs_phase && !r_last_seen_q && (r_count_q <= 4'd4);
    assign w_push          = iface_write_rqst && iface_data_rqst;
    assign w_push_cnt      = {2'b00, iface_write_strb[0]} + {2'b00, iface_write_strb[1]}
                           + {2'b00, iface_write_strb[2]} + {2'b00, iface_write_strb[3]};
    assign w_n             = {2'b00, r_lanes_q} + 4'd1;

    always_comb begin
        w_state_d      = r_state_q;
        w_count_d      = r_count_q;
        w_last_seen_d  = r_last_seen_q;
        w_lanes_d      = r_lanes_q;
        w_lane_data_d  = '0;
        w_lane_valid_d = '0;
        w_pop_cnt      = '0;
        w_push_bytes   = '0;
        w_err_d        = r_err_q && !err_clear;

        // A short pop is only legal once the burst tail is in the buffer.
        if (r_state_q == S_STREAM && phy_hs_active) begin
            if (r_count_q >= w_n) begin
                w_pop_cnt = w_n;
            end else if (r_last_seen_q) begin
                w_pop_cnt = r_count_q;
            end else begin
                w_err_d = 1'b1;
            end
        end

        for (int k = 0; k < 4; k++) begin
            if (4'(k) < w_pop_cnt) begin
                w_lane_valid_d[k]       = 1'b1;
                w_lane_data_d[8*k +: 8] = r_buf_q[8*k +: 8];
            end
            if (iface_write_strb[k]) begin
                w_push_bytes[8*k +: 8] = iface_write_data[8*k +: 8];
            end
        end

        w_remain = r_count_q - w_pop_cnt;
        w_buf_d  = r_buf_q >> {w_pop_cnt, 3'b000};
        if (w_push) begin
            w_buf_d   = w_buf_d | (w_push_bytes << {w_remain, 3'b000});
            w_count_d = w_remain + {1'b0, w_push_cnt};
            if (iface_last_word) begin
                w_last_seen_d = 1'b1;
            end
        end else begin
            w_count_d = w_remain;
        end

        case (r_state_q)
            S_IDLE: begin
                if (iface_write_rqst) begin
                    w_state_d = S_REQUEST;
                    w_lanes_d = lanes_number;
                end
            end
            S_REQUEST: begin
                if (phy_hs_active) begin
                    w_state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (r_last_seen_q && w_count_d == 4'd0) begin
                    w_state_d = S_EXIT;
                end
            end
            S_EXIT: begin
                if (!phy_hs_active) begin
                    w_state_d     = S_IDLE;
                    w_last_seen_d = 1'b0;
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_state_q      <= S_IDLE;
            r_count_q      <= '0;
            r_buf_q        <= '0;
            r_last_seen_q  <= 1'b0;
            r_lanes_q      <= '0;
            r_lane_data_q  <= '0;
            r_lane_valid_q <= '0;
            r_err_q        <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_count_q      <= w_count_d;
            r_buf_q        <= w_buf_d;
            r_last_seen_q  <= w_last_seen_d;
            r_lanes_q      <= w_lanes_d;
            r_lane_data_q  <= w_lane_data_d;
            r_lane_valid_q <= w_lane_valid_d;
            r_err_q        <= w_err_d;
        end
    end

    assign hs_request    = w_hs_phase;
    assign busy          = (r_state_q != S_IDLE);
    assign lane_data     = r_lane_data_q;
    assign lane_valid    = r_lane_valid_q;
    assign underflow_err = r_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dsi_lanes_distributor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_dsi_lanes_distributor
//  Purpose  : Scoreboard bench; expected lane beats come from a byte-list model.
//  Revision : 1.0
// ============================================================================
module tb_dsi_lanes_distributor;

    logic        clk_sys = 1'b0;
    logic        rst;
    logic [31:0] iface_write_data;
    logic [4:0]  iface_write_strb;
    logic        iface_write_rqst;
    logic        iface_last_word;
    logic        iface_data_rqst;
    logic [1:0]  lanes_number;
    logic        phy_hs_active;
    logic        hs_request;
    logic [31:0] lane_data;
    logic [3:0]  lane_valid;
    logic        underflow_err;
    logic        err_clear;
    logic        busy;

    always #5 clk_sys = ~clk_sys;

    dsi_lanes_distributor dut (
        .clk_sys          (clk_sys),
        .rst              (rst),
        .iface_write_data (iface_write_data),
        .iface_write_strb (iface_write_strb),
        .iface_write_rqst (iface_write_rqst),
        .iface_last_word  (iface_last_word),
        .iface_data_rqst  (iface_data_rqst),
        .lanes_number     (lanes_number),
        .phy_hs_active    (phy_hs_active),
        .hs_request       (hs_request),
        .lane_data        (lane_data),
        .lane_valid       (lane_valid),
        .underflow_err    (underflow_err),
        .err_clear        (err_clear),
        .busy             (busy)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  valid;
    } beat_t;

    beat_t       sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          mon_en   = 1'b0;
    logic [31:0] wd[8];
    logic [3:0]  ws[8];
    int          wg[8];
    int          wt[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Burst bytes in wire order, cut into N-byte lane beats; the tail beat may be short.
    task automatic model_expect(input logic [1:0] ln, input int nw);
        logic [7:0] bq[$];
        beat_t      e;
        int         n;
        n = int'(ln) + 1;
        for (int i = 0; i < nw; i++)
            for (int k = 0; k < 4; k++)
                if (ws[i][k]) bq.push_back(wd[i][8*k +: 8]);
        for (int i = 0; i < bq.size(); i += n) begin
            e = '0;
            for (int k = 0; k < n; k++) begin
                if (i + k < bq.size()) begin
                    e.data[8*k +: 8] = bq[i + k];
                    e.valid[k]       = 1'b1;
                end
            end
            sb.push_back(e);
        end
    endtask

    task automatic send_word(input int i, input logic last, output int t);
        t = 0;
        iface_write_data = wd[i];
        iface_write_strb = {(i == 0), ws[i]};
        iface_last_word  = last;
        iface_write_rqst = 1'b1;
        while (!iface_data_rqst && t < 300) begin
            @(negedge clk_sys);
            t++;
        end
        if (t >= 300) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: word %0d not accepted within 300 cycles", i);
        end else begin
            @(negedge clk_sys);
        end
        iface_write_rqst = 1'b0;
        iface_last_word  = 1'b0;
    endtask

    task automatic run_burst(input logic [1:0] ln, input int nw);
        model_expect(ln, nw);
        lanes_number = ln;
        for (int i = 0; i < nw; i++) begin
            repeat (wg[i]) @(negedge clk_sys);
            send_word(i, i == nw - 1, wt[i]);
            lanes_number = ~ln;
        end
    endtask

    task automatic end_burst(input string tag);
        int t;
        t = 0;
        while (!(busy && !hs_request) && t < 300) begin
            @(negedge clk_sys);
            t++;
        end
        check({tag, "_exit_reached"}, 64'(t < 300), 64'd1);
        check({tag, "_final_beat_with_hs_fall"}, 64'(lane_valid != 4'd0), 64'd1);
        repeat (2) @(negedge clk_sys);
        check({tag, "_exit_holds_while_phy_hs"}, 64'(busy), 64'd1);
        phy_hs_active = 1'b0;
        @(negedge clk_sys);
        check({tag, "_idle_after_phy_low"}, 64'(busy), 64'd0);
        phy_hs_active = 1'b1;
        check({tag, "_scoreboard_drained"}, 64'(sb.size()), 64'd0);
    endtask

    always @(negedge clk_sys) begin : monitor
        beat_t e;
        if (mon_en) begin
            if (lane_valid != 4'd0) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got data %h valid %b, expected no beat", lane_data, lane_valid);
                end else begin
                    e = sb.pop_front();
                    check("lane_data", 64'(lane_data), 64'(e.data));
                    check("lane_valid", 64'(lane_valid), 64'(e.valid));
                end
            end else begin
                check("idle_lane_data", 64'(lane_data), 64'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; iface_write_rqst = 1'b1; iface_write_data = 32'h03020100;
        iface_write_strb = 5'h1f; iface_last_word = 1'b0; lanes_number = 2'd3;
        phy_hs_active = 1'b1; err_clear = 1'b0;
        repeat (2) @(posedge clk_sys);
        @(negedge clk_sys);
        check("rst_hs_request", 64'(hs_request), 64'd0);
        check("rst_data_rqst", 64'(iface_data_rqst), 64'd0);
        check("rst_lane_valid", 64'(lane_valid), 64'd0);
        check("rst_lane_data", 64'(lane_data), 64'd0);
        check("rst_underflow", 64'(underflow_err), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        @(negedge clk_sys);
        check("hs_rise_after_release", 64'(hs_request), 64'd1);
        check("busy_after_release", 64'(busy), 64'd1);
        iface_write_rqst = 1'b0;
        rst = 1'b1;
        @(negedge clk_sys);
        check("reset_midburst_drops_hs", 64'(hs_request), 64'd0);
        check("reset_midburst_idle", 64'(busy), 64'd0);
        rst = 1'b0;
        @(negedge clk_sys);
        mon_en = 1'b1;

        // 4 lanes, three full words, with first-word latency measured
        wd[0] = 32'h03020100; wd[1] = 32'h07060504; wd[2] = 32'h0B0A0908;
        for (int i = 0; i < 8; i++) begin ws[i] = 4'hF; wg[i] = 0; end
        fork
            run_burst(2'd3, 3);
            begin
                int t;
                t = 0;
                while (lane_valid == 4'd0 && t < 20) begin
                    @(negedge clk_sys);
                    t++;
                end
                check("first_word_latency", 64'(t), 64'd3);
            end
        join
        end_burst("four_lane");
        check("four_lane_no_underflow", 64'(underflow_err), 64'd0);

        // 3 lanes with a 2-byte tail word
        wd[0] = 32'h03020100; ws[0] = 4'hF;
        wd[1] = 32'h00000504; ws[1] = 4'h3;
        run_burst(2'd2, 2);
        end_burst("three_lane");
        check("three_lane_no_underflow", 64'(underflow_err), 64'd0);

        // 1 lane: the buffer refills only after draining to 4 bytes
        wd[0] = 32'h03020100; wd[1] = 32'h07060504; wd[2] = 32'h0B0A0908;
        ws[0] = 4'hF; ws[1] = 4'hF; ws[2] = 4'hF;
        run_burst(2'd0, 3);
        check("one_lane_second_word_wait", 64'(wt[1]), 64'd0);
        check("one_lane_backpressure_cycles", 64'(wt[2]), 64'd3);
        end_burst("one_lane");
        check("one_lane_no_underflow", 64'(underflow_err), 64'd0);

        // Underflow: second word held back 3 cycles
        wd[0] = 32'h13121110; wd[1] = 32'h17161514;
        wg[1] = 3;
        run_burst(2'd3, 2);
        wg[1] = 0;
        end_burst("underflow");
        check("underflow_set", 64'(underflow_err), 64'd1);
        repeat (3) @(negedge clk_sys);
        check("underflow_sticky", 64'(underflow_err), 64'd1);
        err_clear = 1'b1;
        @(negedge clk_sys);
        err_clear = 1'b0;
        check("underflow_cleared", 64'(underflow_err), 64'd0);

        // PHY drops HS for 2 cycles mid-stream
        wd[0] = 32'h23222120; wd[1] = 32'h27262524; wd[2] = 32'h2B2A2928;
        fork
            run_burst(2'd0, 3);
            begin
                repeat (5) @(negedge clk_sys);
                phy_hs_active = 1'b0;
                @(negedge clk_sys);
                check("stall_no_pop_1", 64'(lane_valid), 64'd0);
                @(negedge clk_sys);
                check("stall_no_pop_2", 64'(lane_valid), 64'd0);
                phy_hs_active = 1'b1;
                check("stall_no_error", 64'(underflow_err), 64'd0);
            end
        join
        end_burst("stall");
        check("stall_burst_no_underflow", 64'(underflow_err), 64'd0);

        // Randomized bursts
        for (int r = 0; r < 24; r++) begin
            int       nw;
            logic [1:0] ln;
            ln = 2'($urandom_range(0, 3));
            nw = int'($urandom_range(1, 6));
            for (int i = 0; i < nw; i++) begin
                wd[i] = $urandom;
                case ($urandom_range(0, 3))
                    0:       ws[i] = 4'h1;
                    1:       ws[i] = 4'h3;
                    2:       ws[i] = 4'h7;
                    default: ws[i] = 4'hF;
                endcase
                wg[i] = (i == 0) ? 0 : int'($urandom_range(0, 2));
            end
            run_burst(ln, nw);
            end_burst("random");
            err_clear = 1'b1;
            @(negedge clk_sys);
            err_clear = 1'b0;
        end

        @(negedge clk_sys);
        check("final_scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dsi_lanes_distributor.md
# dsi_lanes_distributor

Downstream stage of the DSI packet assembler: accepts the 32-bit packet word stream and splits it byte-wise across 1–4 D-PHY data lanes. Owns the per-burst HS entry/exit handshake with the PHY lane controllers. Buffers up to 8 bytes and flags underflow when the upstream stream cannot keep lanes fed mid-burst.

## Interface
- No parameters; lane count is a runtime input.
- clk_sys  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- iface_write_data  in  32  packet bytes; byte0 = [7:0] goes first on the wire
- iface_write_strb  in  5  [3:0] byte enables, contiguous from byte0 (0001/0011/0111/1111); [4] start-of-packet marker, ignored here
- iface_write_rqst  in  1  word valid
- iface_last_word  in  1  last word of the HS burst, qualified by the transfer
- iface_data_rqst  out  1  ready; transfer = iface_write_rqst & iface_data_rqst
- lanes_number  in  2  active lanes minus 1 (0 = 1 lane, 3 = 4 lanes); sampled on IDLE→REQUEST
- phy_hs_active  in  1  all active lanes in HS and accepting one byte per cycle
- hs_request  out  1  request HS mode on the active lanes
- lane_data  out  32  lane j byte on [8j+7:8j]
- lane_valid  out  4  per-lane byte valid
- underflow_err  out  1  sticky; set by a mid-burst stall
- err_clear  in  1  clears underflow_err
- busy  out  1  state != IDLE

## Operation
- Byte buffer: 8 bytes, count 0..8. Pushes append at the tail; pops remove from the head.
- Push: on a transfer, popcount(strb[3:0]) bytes are appended. Non-contiguous strobes are undefined.
- Ready: iface_data_rqst = (state ∈ {REQUEST, STREAM}) & !last_seen & count ≤ 4, so a push always fits.
- last_seen: set by a transfer with iface_last_word; cleared on entry to IDLE.
- N = latched lanes_number + 1.
- Pop in STREAM with phy_hs_active:
  - count ≥ N: pop N bytes.
  - count < N and last_seen: pop all count bytes.
  - otherwise pop 0 and set underflow_err; lanes idle that cycle.
- Lane mapping: popped byte k of a cycle drives lane k, lane_valid[k] = 1. Unused lanes have valid 0 and data 0.
- Because every non-final pop is exactly N bytes, burst byte i always lands on lane i mod N.
- Counter rule: count_next = count − popped + pushed, computed the same cycle.
- FSM:
  - IDLE: if iface_write_rqst, go to REQUEST and latch N. No pushes occur in IDLE; the first word is taken in REQUEST.
  - REQUEST: hs_request = 1; pushes allowed; go to STREAM when phy_hs_active.
  - STREAM: hs_request = 1; go to EXIT when last_seen & count_next == 0.
  - EXIT: hs_request = 0, no pushes or pops; go to IDLE when !phy_hs_active.
- phy_hs_active dropping during STREAM: treated as a stall. No pop and no error; STREAM holds until it returns.
- err_clear and a set condition in the same cycle: set wins.
- lanes_number changes outside IDLE are ignored.

## Timing
- Reset values:
  - State IDLE, count 0, last_seen 0.
  - hs_request, iface_data_rqst, lane_valid, lane_data, underflow_err and busy all 0.
- Reset mid-burst drops hs_request on the next edge and discards buffered bytes.
- lane_data and lane_valid are registered. Bytes popped in cycle t appear in cycle t+1 for exactly one cycle.
- Minimum latency, first word to lane output, with phy_hs_active already high in REQUEST:
  - cycle 0: IDLE sees rqst.
  - cycle 1: REQUEST, push.
  - cycle 2: STREAM, pop.
  - cycle 3: lane_valid high.
- iface_data_rqst is combinational from state, count and last_seen. It never depends on the same cycle's iface_write_rqst.
- Throughput: 4 lanes drain 4 bytes/cycle, so the upstream must supply one full word per cycle to avoid underflow. 1 lane drains 1 byte/cycle and upstream stalls ~3 of every 4 cycles.
- hs_request falls the cycle after the final pop, together with the final lane_valid.

## Test plan
- Reset and idle:
  - Stimulus: assert rst for 2 cycles with iface_write_rqst = 1.
  - Required: all outputs 0; on release, hs_request rises 1 cycle later.
- 4-lane burst:
  - Stimulus: N = 4; three full words 0x03020100, 0x07060504, 0x0B0A0908, the last with iface_last_word; phy_hs_active held high.
  - Required: lane_data 0x03020100, 0x07060504, 0x0B0A0908 on 3 consecutive cycles, lane_valid 1111; underflow_err 0; return to IDLE.
- 3-lane split with partial tail:
  - Stimulus: N = 3; words 0x03020100 (strb 1111) then 0x00000504 (strb 0011, last).
  - Required: lanes get bytes {00,01,02} then {03,04,05}, both with lane_valid 0111; hs_request low after.
- 1-lane backpressure:
  - Stimulus: N = 1; two full words offered back-to-back.
  - Required: 8 consecutive single-byte outputs 00..07 on lane 0; iface_data_rqst low while count > 4.
- Underflow:
  - Stimulus: N = 4; first word sent, second word delayed 3 cycles.
  - Required: lane_valid 0000 for the gap cycles; underflow_err = 1 until err_clear.
- PHY stall and exit:
  - Stimulus: phy_hs_active low for 2 cycles mid-STREAM.
  - Required: no pops and no error during the stall; in EXIT, IDLE is reached only after phy_hs_active falls.
